rete_tabella_programmabile: RTL and testbench

RETE_TABELLA_PROGRAMMABILE -- requirements
Module: rete_tabella_programmabile

---
 rtl/rete_tabella_programmabile.sv | 89 ++++++++
 tb/tb_rete_tabella_programmabile.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rete_tabella_programmabile.sv
// Programmable lookup table: 2^N_IN entries of N_OUT bits, swept to DEFAULT_Z after reset.
// Lookup latency 1 cycle; z/out_valid hold under !out_ready, in_ready drops only when a held result blocks.
module rete_tabella_programmabile #(
   parameter int               N_IN      = 3,
   parameter int               N_OUT     = 2,
   parameter logic [N_OUT-1:0] DEFAULT_Z = '0
) (
   input  logic             clock,
   input  logic             reset_,
   output logic             init_done,
   input  logic             wr_en,
   input  logic [N_IN-1:0]  wr_addr,
   input  logic [N_OUT-1:0] wr_data,
   output logic             wr_ready,
   input  logic             in_valid,
   input  logic [N_IN-1:0]  x,
   output logic             in_ready,
   output logic             out_valid,
   output logic [N_OUT-1:0] z,
   input  logic             out_ready
);

   localparam int DEPTH = 1 << N_IN;

   typedef enum logic {INIT, RUN} state_t;

   state_t           state;
   logic [N_IN-1:0]  count;
   logic [N_OUT-1:0] table_mem [DEPTH];
   logic             mem_we;
   logic [N_IN-1:0]  mem_addr;
   logic [N_OUT-1:0] mem_data;
   logic             lookup;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign lookup   = in_valid && in_ready;

   // Single write port shared by the init sweep and user writes; idle during reset.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = count;
      mem_data = DEFAULT_Z;
      if (reset_) begin
         if (state == INIT) begin
            mem_we = 1'b1;
         end else if (wr_en) begin
            mem_we   = 1'b1;
            mem_addr = wr_addr;
            mem_data = wr_data;
         end
      end
   end

   // No reset on storage; the nonblocking write gives read-before-write on same-address collisions.
   always_ff @(posedge clock) begin
      if (mem_we) table_mem[mem_addr] <= mem_data;
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         state     <= INIT;
         count     <= '0;
         init_done <= 1'b0;
         wr_ready  <= 1'b0;
         out_valid <= 1'b0;
         z         <= '0;
      end else begin
         case (state)
            INIT: begin
               count <= count + 1'b1;
               if (&count) begin
                  state     <= RUN;
                  init_done <= 1'b1;
                  wr_ready  <= 1'b1;
               end
            end
            RUN: begin
               if (lookup) begin
                  z         <= table_mem[x];
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rete_tabella_programmabile.sv
// Bench for rete_tabella_programmabile: scoreboard with a table-level reference model,
// plus a second instance with N_IN=4, N_OUT=3, DEFAULT_Z=3'b101.
module tb_rete_tabella_programmabile;

   logic       clock = 1'b0;
   logic       reset_ = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [1:0] wr_data = '0;
   logic       in_valid = 1'b0;
   logic [2:0] x = '0;
   logic       out_ready = 1'b1;
   logic       init_done, wr_ready, in_ready, out_valid;
   logic [1:0] z;

   logic       b_reset_ = 1'b0;
   logic       b_wr_en = 1'b0;
   logic [3:0] b_wr_addr = '0;
   logic [2:0] b_wr_data = '0;
   logic       b_in_valid = 1'b0;
   logic [3:0] b_x = '0;
   logic       b_out_ready = 1'b1;
   logic       b_init_done, b_wr_ready, b_in_ready, b_out_valid;
   logic [2:0] b_z;

   int checks = 0;
   int failures = 0;

   // Reference model state for instance A
   logic [1:0] model [8];
   logic [1:0] exp_q [$];
   bit         m_known = 0;
   bit         m_run = 0;
   bit         m_ov = 0;
   int         m_cnt = 0;

   always #5 clock = ~clock;

   rete_tabella_programmabile dut (
      .clock(clock), .reset_(reset_), .init_done(init_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .in_valid(in_valid), .x(x), .in_ready(in_ready),
      .out_valid(out_valid), .z(z), .out_ready(out_ready)
   );

   rete_tabella_programmabile #(.N_IN(4), .N_OUT(3), .DEFAULT_Z(3'b101)) dut_b (
      .clock(clock), .reset_(b_reset_), .init_done(b_init_done),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
      .in_valid(b_in_valid), .x(b_x), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .z(b_z), .out_ready(b_out_ready)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: acceptance and table contents derived from the handshake rules only.
   always @(posedge clock) begin
      bit acc;
      if (!reset_) begin
         m_known = 1;
         m_run   = 0;
         m_cnt   = 0;
         m_ov    = 0;
         exp_q.delete();
      end else if (m_known) begin
         if (!m_run) begin
            m_cnt++;
            if (m_cnt == 8) begin
               m_run = 1;
               for (int i = 0; i < 8; i++) model[i] = 2'b00;
            end
         end else begin
            acc = in_valid && (!m_ov || out_ready);
            if (acc) exp_q.push_back(model[x]);
            if (wr_en) model[wr_addr] = wr_data;
            if (acc) m_ov = 1;
            else if (out_ready) m_ov = 0;
         end
      end
   end

   // Monitor: compares handshake outputs and pops results as they are consumed.
   always @(negedge clock) begin
      if (m_known) begin
         chk("init_done", 32'(init_done), 32'(m_run));
         chk("wr_ready", 32'(wr_ready), 32'(m_run));
         chk("in_ready", 32'(in_ready), 32'(m_run && (!m_ov || out_ready)));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               chk("z", 32'(z), 32'(exp_q[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input bit we, input int wa, input int wd,
                         input bit iv, input int xx, input bit ordy);
      wr_en     = we;
      wr_addr   = 3'(wa);
      wr_data   = 2'(wd);
      in_valid  = iv;
      x         = 3'(xx);
      out_ready = ordy;
   endtask

   // Counts edges until init_done, scrambling requests while still in INIT.
   task automatic sweep_a(input string nm);
      int n = 0;
      do begin
         @(posedge clock);
         n++;
         #1;
         set_in(0, 0, 0, 0, 0, 1);
         if (!init_done)
            set_in(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3),
                   1'($urandom), $urandom_range(0, 7), 1'($urandom));
      end while (!init_done && n < 40);
      chk(nm, n, 8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int prog [8] = '{0, 1, 2, 2, 3, 3, 0, 0};

      // Reset and first sweep
      cyc();
      cyc();
      chk("reset_z", 32'(z), 0);
      chk("reset_out_valid", 32'(out_valid), 0);
      reset_ = 1'b1;
      sweep_a("sweep_len_first");

      // All entries default
      for (int i = 0; i < 8; i++) begin
         set_in(0, 0, 0, 1, i, 1);
         cyc();
      end
      set_in(0, 0, 0, 0, 0, 1);
      cyc();

      // Program table, then stream x=0..7 back-to-back
      for (int i = 0; i < 8; i++) begin
         set_in(1, i, prog[i], 0, 0, 1);
         cyc();
      end
      for (int i = 0; i < 8; i++) begin
         set_in(0, 0, 0, 1, i, 1);
         cyc();
      end
      set_in(0, 0, 0, 0, 0, 1);
      cyc();

      // Backpressure: hold z=11 for 3 cycles, blocked lookup waits
      set_in(0, 0, 0, 1, 4, 0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 1, 0, 0);
         cyc();
      end
      set_in(0, 0, 0, 1, 0, 1);
      cyc();
      set_in(0, 0, 0, 0, 0, 1);
      cyc();

      // Same-cycle write and lookup of entry 5: old then new value
      set_in(1, 5, 1, 1, 5, 1);
      cyc();
      set_in(0, 0, 0, 1, 5, 1);
      cyc();
      set_in(0, 0, 0, 0, 0, 1);
      cyc();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 9) < 3), $urandom_range(0, 7), $urandom_range(0, 3),
                1'($urandom), $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
         cyc();
      end

      // Reset with a pending result, then reset again at sweep cycle 4
      set_in(0, 0, 0, 1, 3, 0);
      cyc();
      set_in(0, 0, 0, 0, 0, 0);
      cyc();
      reset_ = 1'b0;
      cyc();
      chk("midop_reset_out_valid", 32'(out_valid), 0);
      reset_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_in(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3),
                1'($urandom), $urandom_range(0, 7), 1'($urandom));
         cyc();
      end
      chk("sweep_not_done_at_4", 32'(init_done), 0);
      set_in(1, 2, 3, 1, 2, 1);
      reset_ = 1'b0;
      cyc();
      reset_ = 1'b1;
      sweep_a("sweep_len_restart");
      for (int i = 0; i < 8; i++) begin
         set_in(0, 0, 0, 1, i, 1);
         cyc();
      end
      set_in(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc();
      chk("scoreboard_drained", exp_q.size(), 0);

      // Parameter variant instance
      b_reset_ = 1'b1;
      n = 0;
      do begin
         @(posedge clock);
         n++;
         #1;
      end while (!b_init_done && n < 60);
      chk("b_sweep_len", n, 16);
      for (int i = 0; i < 16; i++) begin
         b_in_valid = 1'b1;
         b_x = 4'(i);
         cyc();
         chk("b_out_valid", 32'(b_out_valid), 1);
         chk("b_default_z", 32'(b_z), 5);
      end
      b_in_valid = 1'b0;
      b_wr_en = 1'b1;
      b_wr_addr = 4'd9;
      b_wr_data = 3'b010;
      cyc();
      b_wr_en = 1'b0;
      b_in_valid = 1'b1;
      b_x = 4'd9;
      cyc();
      chk("b_written_z", 32'(b_z), 2);
      b_x = 4'd10;
      cyc();
      chk("b_unwritten_z", 32'(b_z), 5);
      b_in_valid = 1'b0;
      cyc();
      chk("b_out_valid_clear", 32'(b_out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
